// File: rtl/oclib_pkg.sv
// rtl/oclib_pkg.sv - shared types and helpers for oclib arbiters
package oclib_pkg;

  localparam int RrMaxInputs  = 16;
  localparam int RrIndexWidth = 4;

  typedef enum logic {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arbState_t;

  typedef struct packed {
    logic                    found;
    logic [RrIndexWidth-1:0] index;
  } rrPick_t;

  // Callers zero-pad the vector to RrMaxInputs; searching modulo 16 then gives
  // the same winner as searching modulo the real requester count.
  function automatic rrPick_t RoundRobinPick(input logic [RrMaxInputs-1:0]  vector,
                                             input logic [RrIndexWidth-1:0] pointer);
    rrPick_t                 pick;
    logic [RrIndexWidth-1:0] candidate;
    pick = '0;
    for (int k = 1; k <= RrMaxInputs; k++) begin
      candidate = pointer + RrIndexWidth'(k);
      if (!pick.found && vector[candidate]) begin
        pick.found = 1'b1;
        pick.index = candidate;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/oclib_ready_valid_arbiter_if.sv
// rtl/oclib_ready_valid_arbiter_if.sv - requester and output channels of the ready/valid arbiter
interface oclib_ready_valid_arbiter_if #(
  parameter int Inputs = 4,
  parameter int Width  = 32
);
  localparam int SourceWidth = $clog2(Inputs);

  logic [Inputs-1:0][Width-1:0] inData;
  logic [Inputs-1:0]            inLast;
  logic [Inputs-1:0]            inValid;
  logic [Inputs-1:0]            inReady;
  logic [Width-1:0]             outData;
  logic                         outLast;
  logic [SourceWidth-1:0]       outSource;
  logic                         outValid;
  logic                         outReady;

  modport master (
    output inData, inLast, inValid, outReady,
    input  inReady, outData, outLast, outSource, outValid
  );

  modport slave (
    input  inData, inLast, inValid, outReady,
    output inReady, outData, outLast, outSource, outValid
  );

endinterface

// File: rtl/oclib_rr_pick.sv
// rtl/oclib_rr_pick.sv - combinational round-robin winner search
module oclib_rr_pick
  import oclib_pkg::*;
#(
  parameter  int Inputs      = 4,
  localparam int SourceWidth = $clog2(Inputs)
) (
  input  logic [Inputs-1:0]      request,
  input  logic [SourceWidth-1:0] pointer,
  output logic [SourceWidth-1:0] index,
  output logic                   any
);

  rrPick_t pick;

  // The range guard is always true for a padded vector; it keeps every index bit live.
  always_comb begin
    pick  = RoundRobinPick(RrMaxInputs'(request), RrIndexWidth'(pointer));
    index = pick.index[SourceWidth-1:0];
    any   = pick.found && ({1'b0, pick.index} < (RrIndexWidth+1)'(Inputs));
  end

endmodule

// File: rtl/oclib_ready_valid_arbiter.sv
// rtl/oclib_ready_valid_arbiter.sv - packet-locked round-robin arbiter with 2-entry output skid
module oclib_ready_valid_arbiter
  import oclib_pkg::*;
#(
  parameter  int Inputs      = 4,
  parameter  int Width       = 32,
  parameter  bit LockOnLast  = 1'b1,
  localparam int SourceWidth = $clog2(Inputs)
) (
  input logic                          clock,
  input logic                          reset,
  oclib_ready_valid_arbiter_if.slave   bus
);

  arbState_t              state;
  arbState_t              nextState;
  logic [SourceWidth-1:0] grant;
  logic [SourceWidth-1:0] rrPointer;
  logic [SourceWidth-1:0] pickIndex;
  logic                   pickAny;
  logic [Inputs-1:0]      inReadyInt;
  logic                   beatAccepted;
  logic                   beatLast;

  logic                   firstValid;
  logic [Width-1:0]       firstData;
  logic                   firstLast;
  logic [SourceWidth-1:0] firstSource;
  logic                   secondValid;
  logic [Width-1:0]       secondData;
  logic                   secondLast;
  logic [SourceWidth-1:0] secondSource;

  oclib_rr_pick #(.Inputs(Inputs)) rrPick (
    .request (bus.inValid),
    .pointer (rrPointer),
    .index   (pickIndex),
    .any     (pickAny)
  );

  assign beatAccepted = bus.inValid[grant] && inReadyInt[grant];
  assign beatLast     = LockOnLast ? bus.inLast[grant] : 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ArbIdle;
      grant     <= '0;
      rrPointer <= SourceWidth'(Inputs - 1);
    end else begin
      state <= nextState;
      if (state == ArbIdle && pickAny) begin
        grant <= pickIndex;
      end
      if (state == ArbLocked && beatAccepted && beatLast) begin
        rrPointer <= grant;
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      ArbIdle:   if (pickAny) nextState = ArbLocked;
      ArbLocked: if (beatAccepted && beatLast) nextState = ArbIdle;
      default:   nextState = ArbIdle;
    endcase
  end

  // Ready comes only from flops so upstream never sees a valid-to-ready path.
  always_comb begin
    inReadyInt = '0;
    if (state == ArbLocked) begin
      inReadyInt[grant] = ~secondValid;
    end
  end

  assign bus.inReady = inReadyInt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      firstValid   <= 1'b0;
      firstData    <= '0;
      firstLast    <= 1'b0;
      firstSource  <= '0;
      secondValid  <= 1'b0;
      secondData   <= '0;
      secondLast   <= 1'b0;
      secondSource <= '0;
    end else begin
      if (!secondValid) begin
        firstValid  <= beatAccepted;
        firstData   <= bus.inData[grant];
        firstLast   <= beatLast;
        firstSource <= grant;
      end
      if (!secondValid && !bus.outReady) begin
        secondValid  <= firstValid;
        secondData   <= firstData;
        secondLast   <= firstLast;
        secondSource <= firstSource;
      end else if (bus.outReady) begin
        secondValid <= 1'b0;
      end
    end
  end

  assign bus.outValid  = firstValid | secondValid;
  assign bus.outData   = secondValid ? secondData   : firstData;
  assign bus.outLast   = secondValid ? secondLast   : firstLast;
  assign bus.outSource = secondValid ? secondSource : firstSource;

endmodule

// File: tb/tb_oclib_ready_valid_arbiter.sv
// tb/tb_oclib_ready_valid_arbiter.sv - directed bench for the ready/valid arbiter
module tb_oclib_ready_valid_arbiter;

  localparam int Inputs = 4;
  localparam int Width  = 32;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  beat_t monQ[$];

  always #5 clock = ~clock;

  oclib_ready_valid_arbiter_if #(.Inputs(Inputs), .Width(Width)) a();
  oclib_ready_valid_arbiter_if #(.Inputs(Inputs), .Width(Width)) b();

  oclib_ready_valid_arbiter #(.Inputs(Inputs), .Width(Width), .LockOnLast(1'b1)) dutLock (
    .clock (clock),
    .reset (reset),
    .bus   (a)
  );

  oclib_ready_valid_arbiter #(.Inputs(Inputs), .Width(Width), .LockOnLast(1'b0)) dutBeat (
    .clock (clock),
    .reset (reset),
    .bus   (b)
  );

  function automatic beat_t mk(input logic [1:0] src, input logic [31:0] data, input logic last);
    beat_t x;
    x.src  = src;
    x.data = data;
    x.last = last;
    return x;
  endfunction

  always @(negedge clock) begin
    if (reset && a.outValid && a.outReady) monQ.push_back(mk(a.outSource, a.outData, a.outLast));
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    a.inValid = '0; a.inData = '0; a.inLast = '0; a.outReady = 1'b1;
    b.inValid = '0; b.inData = '0; b.inLast = '0; b.outReady = 1'b1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  task automatic aSend(input int src, input logic [31:0] data, input logic last);
    logic ok;
    bit   done;
    done = 1'b0;
    a.inValid[src] = 1'b1;
    a.inData[src]  = data;
    a.inLast[src]  = last;
    for (int n = 0; n < 30 && !done; n++) begin
      ok = a.inReady[src];
      cyc();
      if (ok) done = 1'b1;
    end
    a.inValid[src] = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL send_timeout src=%0d data=%h: accepted=0 required=1", src, data);
    end
  endtask

  task automatic test_reset();
    clearInputs();
    reset = 1'b0;
    a.inValid = '1;
    b.inValid = '1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if (a.inReady !== 4'b0000) begin failures++; $display("FAIL reset_inReady_lock cyc%0d: got %b want 0000", k, a.inReady); end
      checks++;
      if (a.outValid !== 1'b0) begin failures++; $display("FAIL reset_outValid_lock cyc%0d: got %b want 0", k, a.outValid); end
      checks++;
      if (b.inReady !== 4'b0000) begin failures++; $display("FAIL reset_inReady_beat cyc%0d: got %b want 0000", k, b.inReady); end
      checks++;
      if (b.outValid !== 1'b0) begin failures++; $display("FAIL reset_outValid_beat cyc%0d: got %b want 0", k, b.outValid); end
    end
    reset = 1'b1;
    cyc();
    checks++;
    if (a.inReady !== 4'b0001) begin failures++; $display("FAIL reset_first_grant_lock: got %b want 0001", a.inReady); end
    checks++;
    if (b.inReady !== 4'b0001) begin failures++; $display("FAIL reset_first_grant_beat: got %b want 0001", b.inReady); end
  endtask

  task automatic test_round_robin();
    logic [1:0] expSrc;
    clearInputs();
    b.inValid = '1;
    for (int i = 0; i < Inputs; i++) b.inData[i] = 32'(i);
    doReset();
    for (int k = 1; k <= 12; k++) begin
      cyc();
      checks++;
      if (b.outValid !== ((k % 2) == 0)) begin
        failures++;
        $display("FAIL rr_outValid cyc%0d: got %b want %b", k, b.outValid, ((k % 2) == 0));
      end
      if ((k % 2) == 0) begin
        expSrc = 2'((k / 2 - 1) % 4);
        checks++;
        if (b.outSource !== expSrc) begin failures++; $display("FAIL rr_outSource cyc%0d: got %0d want %0d", k, b.outSource, expSrc); end
        checks++;
        if (b.outData !== 32'(expSrc)) begin failures++; $display("FAIL rr_outData cyc%0d: got %h want %h", k, b.outData, 32'(expSrc)); end
        checks++;
        if (b.outLast !== 1'b1) begin failures++; $display("FAIL rr_outLast cyc%0d: got %b want 1", k, b.outLast); end
      end
    end
  endtask

  task automatic test_packet_lock();
    beat_t exp[$];
    beat_t got;
    clearInputs();
    doReset();
    monQ.delete();
    aSend(2, 32'h20, 1'b0);
    a.inValid[1] = 1'b1; a.inData[1] = 32'h10; a.inLast[1] = 1'b1;
    aSend(2, 32'h21, 1'b0);
    aSend(2, 32'h22, 1'b1);
    aSend(1, 32'h10, 1'b1);
    repeat (3) cyc();
    exp = {mk(2, 32'h20, 0), mk(2, 32'h21, 0), mk(2, 32'h22, 1), mk(1, 32'h10, 1)};
    checks++;
    if (monQ.size() != exp.size()) begin failures++; $display("FAIL lock_count: got %0d want %0d", monQ.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = '0;
      if (i < monQ.size()) got = monQ[i];
      checks++;
      if (got !== exp[i]) begin failures++; $display("FAIL lock_beat%0d: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    beat_t exp[$];
    beat_t got;
    clearInputs();
    doReset();
    monQ.delete();
    a.outReady = 1'b0;
    aSend(0, 32'hA0, 1'b0);
    aSend(0, 32'hA1, 1'b0);
    a.inValid[0] = 1'b1; a.inData[0] = 32'hA2; a.inLast[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      checks++;
      if (a.inReady !== 4'b0000) begin failures++; $display("FAIL bp_inReady cyc%0d: got %b want 0000", k, a.inReady); end
    end
    checks++;
    if (a.outValid !== 1'b1) begin failures++; $display("FAIL bp_outValid: got %b want 1", a.outValid); end
    checks++;
    if (a.outData !== 32'hA0) begin failures++; $display("FAIL bp_outData_head: got %h want a0", a.outData); end
    a.outReady = 1'b1;
    aSend(0, 32'hA2, 1'b0);
    aSend(0, 32'hA3, 1'b0);
    aSend(0, 32'hA4, 1'b1);
    repeat (4) cyc();
    exp = {mk(0, 32'hA0, 0), mk(0, 32'hA1, 0), mk(0, 32'hA2, 0), mk(0, 32'hA3, 0), mk(0, 32'hA4, 1)};
    checks++;
    if (monQ.size() != exp.size()) begin failures++; $display("FAIL bp_count: got %0d want %0d", monQ.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = '0;
      if (i < monQ.size()) got = monQ[i];
      checks++;
      if (got !== exp[i]) begin failures++; $display("FAIL bp_beat%0d: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_mid_gap();
    beat_t exp[$];
    beat_t got;
    clearInputs();
    doReset();
    monQ.delete();
    aSend(3, 32'h30, 1'b0);
    a.inValid[0] = 1'b1; a.inData[0] = 32'h40; a.inLast[0] = 1'b1;
    a.inValid[1] = 1'b1; a.inData[1] = 32'h41; a.inLast[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (a.inReady !== 4'b1000) begin failures++; $display("FAIL gap_grant_held cyc%0d: got %b want 1000", k, a.inReady); end
    end
    aSend(3, 32'h31, 1'b0);
    aSend(3, 32'h32, 1'b1);
    aSend(0, 32'h40, 1'b1);
    aSend(1, 32'h41, 1'b1);
    repeat (3) cyc();
    exp = {mk(3, 32'h30, 0), mk(3, 32'h31, 0), mk(3, 32'h32, 1), mk(0, 32'h40, 1), mk(1, 32'h41, 1)};
    checks++;
    if (monQ.size() != exp.size()) begin failures++; $display("FAIL gap_count: got %0d want %0d", monQ.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      got = '0;
      if (i < monQ.size()) got = monQ[i];
      checks++;
      if (got !== exp[i]) begin failures++; $display("FAIL gap_beat%0d: got %h want %h", i, got, exp[i]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    clearInputs();
    doReset();
    aSend(1, 32'h60, 1'b1);
    aSend(2, 32'h70, 1'b0);
    aSend(2, 32'h71, 1'b0);
    a.inValid[2] = 1'b1; a.inData[2] = 32'h72; a.inLast[2] = 1'b0;
    checks++;
    if (a.outValid !== 1'b1) begin failures++; $display("FAIL rstmid_beat2_visible: got %b want 1", a.outValid); end
    reset = 1'b0;
    #1;
    checks++;
    if (a.outValid !== 1'b0) begin failures++; $display("FAIL rstmid_outValid_async: got %b want 0", a.outValid); end
    checks++;
    if (a.inReady !== 4'b0000) begin failures++; $display("FAIL rstmid_inReady_async: got %b want 0000", a.inReady); end
    cyc();
    cyc();
    a.inValid = 4'b0110;
    reset = 1'b1;
    checks++;
    if (a.inReady !== 4'b0000) begin failures++; $display("FAIL rstmid_idle_after_release: got %b want 0000", a.inReady); end
    cyc();
    checks++;
    if (a.inReady !== 4'b0010) begin failures++; $display("FAIL rstmid_pointer_reset_grant: got %b want 0010", a.inReady); end
    clearInputs();
  endtask

  initial begin
    clearInputs();
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_mid_gap();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
